// File: rtl/conv_window_sequencer_if.sv
// Bus between conv_window_sequencer (master) and its environment: job control,
// picture/weight SRAM read ports, MAC feed and result strobe.
interface conv_window_sequencer_if #(
  parameter int BIT     = 8,
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 4
);
  logic               start;
  logic [1:0]         norm_mode_cfg;
  logic               busy;
  logic               done;
  logic               pic_rd_en;
  logic [ADDR_W-1:0]  pic_addr;
  logic [BIT-1:0]     pic_rdata;
  logic               w_rd_en;
  logic [WADDR_W-1:0] w_addr;
  logic [BIT-1:0]     w_rdata;
  logic [BIT-1:0]     picture;
  logic [BIT-1:0]     weight;
  logic               accumulator_en;
  logic [1:0]         normalizer_mode;
  logic               acc_clr;
  logic               res_valid;
  logic [ADDR_W-1:0]  res_addr;

  modport master (
    input  start, norm_mode_cfg, pic_rdata, w_rdata,
    output busy, done, pic_rd_en, pic_addr, w_rd_en, w_addr, picture, weight,
           accumulator_en, normalizer_mode, acc_clr, res_valid, res_addr
  );

  modport slave (
    output start, norm_mode_cfg, pic_rdata, w_rdata,
    input  busy, done, pic_rd_en, pic_addr, w_rd_en, w_addr, picture, weight,
           accumulator_en, normalizer_mode, acc_clr, res_valid, res_addr
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks every valid KxK window of an IMG_W x IMG_W image and sequences picture/weight reads
// into the MAC. Define CONV_SEQ_PERF_EN to add the perf_cycles busy-cycle counter port.
module conv_window_sequencer #(
  parameter int BIT     = 8,
  parameter int IMG_W   = 28,
  parameter int K       = 3,
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 4,
  parameter int MAC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  conv_window_sequencer_if.master bus
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int DW    = $clog2(MAC_LAT + 2);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic [WADDR_W-1:0] r_kx, r_ky;
  logic [ADDR_W-1:0]  r_ox, r_oy;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  r_res_addr;
  logic [DW-1:0]      r_drain;
  logic               r_pic_rd_en, r_acc_en, r_acc_clr, r_res_valid, r_busy, r_done;
  logic [ADDR_W-1:0]  r_pic_addr;
  logic [WADDR_W-1:0] r_w_addr;
  logic [1:0]         r_mode;

  logic w_last_tap, w_last_win, w_kx_wrap, w_ox_wrap;

  assign w_kx_wrap  = (r_kx == WADDR_W'(K - 1));
  assign w_last_tap = w_kx_wrap && (r_ky == WADDR_W'(K - 1));
  assign w_ox_wrap  = (r_ox == ADDR_W'(OUT_W - 1));
  assign w_last_win = w_ox_wrap && (r_oy == ADDR_W'(OUT_W - 1));

  // r_base tracks oy*IMG_W+ox and r_pic_addr steps from it, so no multipliers are needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_kx        <= '0;
      r_ky        <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_base      <= '0;
      r_res_addr  <= '0;
      r_drain     <= '0;
      r_pic_rd_en <= 1'b0;
      r_acc_en    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pic_addr  <= '0;
      r_w_addr    <= '0;
      r_mode      <= '0;
    end else begin
      r_acc_en <= r_pic_rd_en;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_CLR;
            r_busy     <= 1'b1;
            r_acc_clr  <= 1'b1;
            r_mode     <= bus.norm_mode_cfg;
            r_ox       <= '0;
            r_oy       <= '0;
            r_base     <= '0;
            r_res_addr <= '0;
          end
        end
        S_CLR: begin
          r_state     <= S_RUN;
          r_acc_clr   <= 1'b0;
          r_pic_rd_en <= 1'b1;
          r_pic_addr  <= r_base;
          r_w_addr    <= '0;
          r_kx        <= '0;
          r_ky        <= '0;
        end
        S_RUN: begin
          if (w_last_tap) begin
            r_state     <= S_DRAIN;
            r_pic_rd_en <= 1'b0;
            r_drain     <= '0;
            r_res_valid <= (MAC_LAT == 0);
          end else begin
            r_w_addr <= r_w_addr + 1'b1;
            if (w_kx_wrap) begin
              r_kx       <= '0;
              r_ky       <= r_ky + 1'b1;
              r_pic_addr <= r_pic_addr + ADDR_W'(IMG_W - K + 1);
            end else begin
              r_kx       <= r_kx + 1'b1;
              r_pic_addr <= r_pic_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          r_drain     <= r_drain + 1'b1;
          r_res_valid <= (int'(r_drain) + 1 == MAC_LAT);
          if (int'(r_drain) == MAC_LAT) begin
            r_res_valid <= 1'b0;
            if (w_last_win) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= S_CLR;
              r_acc_clr  <= 1'b1;
              r_res_addr <= r_res_addr + 1'b1;
              if (w_ox_wrap) begin
                r_ox   <= '0;
                r_oy   <= r_oy + 1'b1;
                r_base <= r_base + ADDR_W'(K);
              end else begin
                r_ox   <= r_ox + 1'b1;
                r_base <= r_base + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pic_rd_en       = r_pic_rd_en;
  assign bus.pic_addr        = r_pic_addr;
  assign bus.w_rd_en         = r_pic_rd_en;
  assign bus.w_addr          = r_w_addr;
  assign bus.picture         = bus.pic_rdata;
  assign bus.weight          = bus.w_rdata;
  assign bus.accumulator_en  = r_acc_en;
  assign bus.normalizer_mode = r_mode;
  assign bus.acc_clr         = r_acc_clr;
  assign bus.res_valid       = r_res_valid;
  assign bus.res_addr        = r_res_addr;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_perf <= '0;
    end else if (r_busy && r_perf != '1) begin
      r_perf <= r_perf + 1'b1;
    end
  end

  assign perf_cycles = r_perf;
`endif
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: random image/weights, reference read
// schedule built from nested window loops, scenario tasks run in sequence.
module tb_conv_window_sequencer;
  localparam int BIT     = 8;
  localparam int IMG_W   = 28;
  localparam int K       = 3;
  localparam int ADDR_W  = 10;
  localparam int WADDR_W = 4;
  localparam int MAC_LAT = 2;
  localparam int OUT_W   = IMG_W - K + 1;
  localparam int NWIN    = OUT_W * OUT_W;
  localparam int TAPS    = K * K;
  localparam int JOB_CYC = NWIN * (1 + TAPS + MAC_LAT + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [BIT-1:0] img [0:(1<<ADDR_W)-1];
  logic [BIT-1:0] wts [0:(1<<WADDR_W)-1];
  int exp_pa[$];
  int exp_wa[$];

  conv_window_sequencer_if #(.BIT(BIT), .ADDR_W(ADDR_W), .WADDR_W(WADDR_W)) bus ();

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  conv_window_sequencer #(
    .BIT(BIT), .IMG_W(IMG_W), .K(K), .ADDR_W(ADDR_W), .WADDR_W(WADDR_W), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef CONV_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // SRAM models with one cycle of read latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pic_rdata <= '0;
      bus.w_rdata   <= '0;
    end else begin
      if (bus.pic_rd_en) bus.pic_rdata <= img[bus.pic_addr];
      if (bus.w_rd_en)   bus.w_rdata   <= wts[bus.w_addr];
    end
  end

  function automatic void build_model();
    for (int i = 0; i < (1 << ADDR_W); i++) img[i] = BIT'($urandom);
    for (int i = 0; i < (1 << WADDR_W); i++) wts[i] = BIT'($urandom);
    for (int oy = 0; oy < OUT_W; oy++)
      for (int ox = 0; ox < OUT_W; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            exp_pa.push_back((oy + ky) * IMG_W + ox + kx);
            exp_wa.push_back(ky * K + kx);
          end
  endfunction

  task automatic test_reset();
    logic [48:0] outs;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      outs = {bus.busy, bus.done, bus.pic_rd_en, bus.pic_addr, bus.w_rd_en, bus.w_addr,
              bus.picture, bus.weight, bus.accumulator_en, bus.normalizer_mode, bus.acc_clr,
              bus.res_valid, bus.res_addr};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d outputs=%h expected 0", c, outs);
      end
      @(negedge clk);
    end
`ifdef CONV_SEQ_PERF_EN
    checks++;
    if (perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got %0d expected 0", perf_cycles);
    end
`endif
  endtask

  task automatic test_full_job();
    int rd_idx = 0, res_idx = 0, busy_cyc = 0, last_rd = -100;
    bit seen_done = 1'b0, prev_rd = 1'b0;
    int prev_pa = 0, prev_wa = 0;
    bus.norm_mode_cfg = 2'b01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.norm_mode_cfg = 2'($urandom);
    for (int cyc = 0; cyc < JOB_CYC + 200 && !seen_done; cyc++) begin
      if (bus.busy) busy_cyc++;
      checks++;
      if (bus.accumulator_en !== prev_rd || bus.w_rd_en !== bus.pic_rd_en) begin
        errors++;
        $display("FAIL acc_en_align cycle %0d acc_en=%b w_rd_en=%b rd_en=%b expected acc_en=%b",
                 cyc, bus.accumulator_en, bus.w_rd_en, bus.pic_rd_en, prev_rd);
      end
      if (bus.accumulator_en) begin
        checks++;
        if (bus.picture !== img[prev_pa] || bus.weight !== wts[prev_wa]) begin
          errors++;
          $display("FAIL mac_data cycle %0d pic=%h w=%h expected pic=%h w=%h",
                   cyc, bus.picture, bus.weight, img[prev_pa], wts[prev_wa]);
        end
      end
      checks++;
      if (bus.acc_clr && bus.accumulator_en) begin
        errors++;
        $display("FAIL clr_overlap cycle %0d acc_clr=1 acc_en=1 expected not both", cyc);
      end
      if (bus.busy) begin
        checks++;
        if (bus.normalizer_mode !== 2'b01) begin
          errors++;
          $display("FAIL norm_mode cycle %0d got %b expected 01", cyc, bus.normalizer_mode);
        end
      end
      if (bus.pic_rd_en) begin
        checks++;
        if (rd_idx >= exp_pa.size() || int'(bus.pic_addr) != exp_pa[rd_idx]
            || int'(bus.w_addr) != exp_wa[rd_idx]) begin
          errors++;
          $display("FAIL read_addr read %0d pic_addr=%0d w_addr=%0d expected %0d/%0d", rd_idx,
                   bus.pic_addr, bus.w_addr, (rd_idx < exp_pa.size()) ? exp_pa[rd_idx] : -1,
                   (rd_idx < exp_wa.size()) ? exp_wa[rd_idx] : -1);
        end
        last_rd = cyc;
        rd_idx++;
      end
      if (bus.res_valid) begin
        checks++;
        if (int'(bus.res_addr) != res_idx || cyc != last_rd + 1 + MAC_LAT
            || rd_idx != (res_idx + 1) * TAPS) begin
          errors++;
          $display("FAIL result res_addr=%0d cyc=%0d reads=%0d expected %0d/%0d/%0d",
                   bus.res_addr, cyc, rd_idx, res_idx, last_rd + 1 + MAC_LAT,
                   (res_idx + 1) * TAPS);
        end
        res_idx++;
      end
      if (bus.done) begin
        seen_done = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || busy_cyc != JOB_CYC) begin
          errors++;
          $display("FAIL done_timing busy=%b busy_cycles=%0d expected 0/%0d",
                   bus.busy, busy_cyc, JOB_CYC);
        end
      end
      prev_rd = bus.pic_rd_en;
      prev_pa = int'(bus.pic_addr);
      prev_wa = int'(bus.w_addr);
      @(negedge clk);
    end
    checks++;
    if (!seen_done || rd_idx != NWIN * TAPS || res_idx != NWIN) begin
      errors++;
      $display("FAIL job_totals done=%b reads=%0d results=%0d expected 1/%0d/%0d",
               seen_done, rd_idx, res_idx, NWIN * TAPS, NWIN);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL post_done busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
`ifdef CONV_SEQ_PERF_EN
    repeat (5) @(negedge clk);
    checks++;
    if (perf_cycles !== 32'(JOB_CYC)) begin
      errors++;
      $display("FAIL perf_total got %0d expected %0d", perf_cycles, JOB_CYC);
    end
`endif
  endtask

  task automatic test_ignored_start();
    int rd_idx = 0, res_idx = 0, busy_cyc = 0;
    bit seen_done = 1'b0;
    bus.norm_mode_cfg = 2'b10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
`ifdef CONV_SEQ_PERF_EN
    checks++;
    if (perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_clear got %0d expected 0", perf_cycles);
    end
`endif
    for (int cyc = 0; cyc < JOB_CYC + 200 && !seen_done; cyc++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        seen_done = 1'b1;
        checks++;
        if (busy_cyc != JOB_CYC) begin
          errors++;
          $display("FAIL restart_done busy_cycles=%0d expected %0d", busy_cyc, JOB_CYC);
        end
      end else begin
        checks++;
        if (bus.busy !== 1'b1 || bus.normalizer_mode !== 2'b10) begin
          errors++;
          $display("FAIL no_restart cycle %0d busy=%b mode=%b expected 1/10",
                   cyc, bus.busy, bus.normalizer_mode);
        end
      end
      if (bus.pic_rd_en) begin
        checks++;
        if (rd_idx >= exp_pa.size() || int'(bus.pic_addr) != exp_pa[rd_idx]) begin
          errors++;
          $display("FAIL unbroken_addr read %0d got %0d expected %0d", rd_idx, bus.pic_addr,
                   (rd_idx < exp_pa.size()) ? exp_pa[rd_idx] : -1);
        end
        rd_idx++;
      end
      if (bus.res_valid) begin
        checks++;
        if (int'(bus.res_addr) != res_idx) begin
          errors++;
          $display("FAIL unbroken_res got %0d expected %0d", bus.res_addr, res_idx);
        end
        res_idx++;
      end
      // stray start and config change mid-job, then a start coinciding with DONE
      bus.start = (cyc == 100) || bus.done;
      if (cyc == 100) bus.norm_mode_cfg = 2'b11;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (!seen_done || res_idx != NWIN) begin
      errors++;
      $display("FAIL restart_totals done=%b results=%0d expected 1/%0d", seen_done, res_idx, NWIN);
    end
    repeat (2) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.acc_clr !== 1'b0) begin
        errors++;
        $display("FAIL start_in_done busy=%b acc_clr=%b expected 0/0", bus.busy, bus.acc_clr);
      end
      @(negedge clk);
    end
`ifdef CONV_SEQ_PERF_EN
    checks++;
    if (perf_cycles !== 32'(JOB_CYC)) begin
      errors++;
      $display("FAIL perf_hold got %0d expected %0d", perf_cycles, JOB_CYC);
    end
`endif
  endtask

  task automatic test_abort_reset();
    int res_idx = 0, rd_idx = 0;
    bit aborted = 1'b0, got_res = 1'b0;
    logic [32:0] outs;
    bus.norm_mode_cfg = 2'b11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 400 * 13 && !aborted; cyc++) begin
      if (bus.res_valid) res_idx++;
      if (res_idx == 300 && bus.pic_rd_en) begin
        rst_n = 1'b0;
        #1;
        outs = {bus.busy, bus.done, bus.pic_rd_en, bus.pic_addr, bus.w_rd_en, bus.w_addr,
                bus.accumulator_en, bus.normalizer_mode, bus.acc_clr, bus.res_valid,
                bus.res_addr};
        checks++;
        if (outs !== '0) begin
          errors++;
          $display("FAIL abort_outputs got %h expected 0", outs);
        end
`ifdef CONV_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 32'd0) begin
          errors++;
          $display("FAIL abort_perf got %0d expected 0", perf_cycles);
        end
`endif
        aborted = 1'b1;
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    checks++;
    if (!aborted) begin
      errors++;
      $display("FAIL abort_reach window 300 not reached, results=%0d", res_idx);
    end
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (bus.done !== 1'b0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0
          || bus.pic_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d done=%b res_valid=%b busy=%b rd_en=%b expected 0",
                 c, bus.done, bus.res_valid, bus.busy, bus.pic_rd_en);
      end
      @(negedge clk);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 50 && !got_res; cyc++) begin
      if (bus.pic_rd_en) begin
        checks++;
        if (rd_idx >= TAPS || int'(bus.pic_addr) != exp_pa[rd_idx]) begin
          errors++;
          $display("FAIL restart_addr read %0d got %0d expected %0d", rd_idx, bus.pic_addr,
                   (rd_idx < TAPS) ? exp_pa[rd_idx] : -1);
        end
        rd_idx++;
      end
      if (bus.res_valid) begin
        got_res = 1'b1;
        checks++;
        if (bus.res_addr !== '0 || rd_idx != TAPS) begin
          errors++;
          $display("FAIL restart_res res_addr=%0d reads=%0d expected 0/%0d",
                   bus.res_addr, rd_idx, TAPS);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!got_res) begin
      errors++;
      $display("FAIL restart_timeout no res_valid within 50 cycles");
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.norm_mode_cfg = 2'b00;
    build_model();
    test_reset();
    test_full_job();
    test_ignored_start();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
